// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared types for the memory-controller arbiter: request type, block address/data, response tag.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mem_ctrl_arbiter_pkg;

    localparam int ADDR_W  = 26;    // main-memory block address width
    localparam int BLOCK_W = 64;    // block data width
    localparam int MAX_CH  = 2;     // channel count the tag layout is sized for
    localparam int CH_ID_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    typedef logic [ADDR_W-1:0]  main_mem_block_addr_t;
    typedef logic [BLOCK_W-1:0] block_data_t;

    // One entry per accepted request; drop marks a response nobody wants any more.
    typedef struct packed {
        logic [CH_ID_W-1:0] chan_id;
        logic               drop;
    } mem_tag_t;

    // Round-robin successor that also works when n is not a power of two.
    function automatic logic [CH_ID_W-1:0] next_chan(input logic [CH_ID_W-1:0] c, input int n);
        return (int'(c) == n - 1) ? '0 : c + CH_ID_W'(1);
    endfunction

endpackage

// File: rtl/mem_ctrl_arbiter_if.sv
// Bundle of channel-side and memory-side signals around the arbiter, plus its status outputs.
// Latency: n/a (wiring only).
// Backpressure: ch_req_ready / mem_req_ready valid-ready pairs; responses cannot be stalled.
//  master : arbiter view (drives mem_req_*, ch_req_ready, ch_resp_*, status)
//  slave  : environment view (cache channels + main memory)
interface mem_ctrl_arbiter_if
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int MAX_OUTST = 4
) ();
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic [N_CH-1:0]                  ch_req_valid;
    req_type_t [N_CH-1:0]             ch_req_type;
    main_mem_block_addr_t [N_CH-1:0]  ch_req_block_addr;
    block_data_t [N_CH-1:0]           ch_req_block_data;
    logic [N_CH-1:0]                  ch_req_ready;
    logic [N_CH-1:0]                  ch_flush;
    logic [N_CH-1:0]                  ch_resp_valid;
    block_data_t                      ch_resp_block_data;

    logic                             mem_req_valid;
    req_type_t                        mem_req_type;
    main_mem_block_addr_t             mem_req_block_addr;
    block_data_t                      mem_req_block_data;
    logic                             mem_req_ready;
    logic                             mem_resp_valid;
    block_data_t                      mem_resp_block_data;

    logic [CNT_W-1:0]                 outst_cnt;
    logic                             err_unexp_resp;

    modport master (
        input  ch_req_valid, ch_req_type, ch_req_block_addr, ch_req_block_data, ch_flush,
               mem_req_ready, mem_resp_valid, mem_resp_block_data,
        output ch_req_ready, ch_resp_valid, ch_resp_block_data,
               mem_req_valid, mem_req_type, mem_req_block_addr, mem_req_block_data,
               outst_cnt, err_unexp_resp
    );

    modport slave (
        output ch_req_valid, ch_req_type, ch_req_block_addr, ch_req_block_data, ch_flush,
               mem_req_ready, mem_resp_valid, mem_resp_block_data,
        input  ch_req_ready, ch_resp_valid, ch_resp_block_data,
               mem_req_valid, mem_req_type, mem_req_block_addr, mem_req_block_data,
               outst_cnt, err_unexp_resp
    );
endinterface

// File: rtl/mem_ctrl_arbiter_tag_fifo.sv
// Circular in-order FIFO of response tags with a per-channel drop-bit broadcast.
// Latency: push/pop take effect at the next clock; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty (caller gates both).
// Ports: clk, rst (sync, active-high), push/push_tag, pop, flush[N_CH], head, empty, full, count.
module mem_tag_fifo
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,            // power of 2, >= 2
    parameter int N_CH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  mem_tag_t                   push_tag,
    input  logic                       pop,
    input  logic [N_CH-1:0]            flush,
    output mem_tag_t                   head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mem_tag_t            entries [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    cnt;
    logic                push_ok;
    logic                pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = entries[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            // Stale slots may get their drop bit set too; harmless, they are rewritten on push.
            for (int i = 0; i < DEPTH; i++) begin
                if (flush[entries[i].chan_id]) begin
                    entries[i].drop <= 1'b1;
                end
            end
            // Placed after the broadcast so a fresh push overrides whatever was in the slot.
            if (push_ok) begin
                entries[wr_ptr] <= push_tag;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Round-robin arbiter from N cache channels onto one main-memory port, with in-order response routing.
// Latency: request path combinational (0 cycles); response to channel registered (1 cycle).
// Backpressure: only the granted channel sees ready; full tag FIFO stalls all; responses cannot stall.
// Ports: clk, rst (sync, active-high), bus (mem_ctrl_arbiter_if.master: channel, memory and status signals).
module mem_ctrl_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_ctrl_arbiter_if.master   bus
);
    logic [CH_ID_W-1:0]  rr_ptr;
    logic [CH_ID_W-1:0]  gnt_id;
    logic                gnt_found;
    int                  idx;
    logic                full;
    logic                empty;
    logic                req_vld;
    logic                accept;
    logic                pop;
    mem_tag_t            push_tag;
    mem_tag_t            head;
    logic [N_CH-1:0]     ready;

    // First valid channel at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!gnt_found && bus.ch_req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = CH_ID_W'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (gnt_found && bus.mem_req_ready && !full) begin
            ready[gnt_id] = 1'b1;
        end
    end

    assign req_vld                = gnt_found && !full;
    assign accept                 = req_vld && bus.mem_req_ready;
    assign bus.mem_req_valid      = req_vld;
    assign bus.mem_req_type       = bus.ch_req_type[gnt_id];
    assign bus.mem_req_block_addr = bus.ch_req_block_addr[gnt_id];
    assign bus.mem_req_block_data = bus.ch_req_block_data[gnt_id];
    assign bus.ch_req_ready       = ready;

    // A request accepted while its own channel is flushing is born dead.
    assign push_tag.chan_id = gnt_id;
    assign push_tag.drop    = bus.ch_flush[gnt_id];

    assign pop = bus.mem_resp_valid && !empty;

    mem_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .N_CH  (N_CH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_tag (push_tag),
        .pop      (pop),
        .flush    (bus.ch_flush),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .count    (bus.outst_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= next_chan(gnt_id, N_CH);
        end
    end

    // Head tag's drop bit only covers flushes up to last cycle; a flush in the pop cycle is checked live.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ch_resp_valid      <= '0;
            bus.ch_resp_block_data <= '0;
            bus.err_unexp_resp     <= 1'b0;
        end else begin
            bus.ch_resp_valid <= '0;
            if (pop && !head.drop && !bus.ch_flush[head.chan_id]) begin
                bus.ch_resp_valid[head.chan_id] <= 1'b1;
                bus.ch_resp_block_data          <= bus.mem_resp_block_data;
            end
            if (bus.mem_resp_valid && empty) begin
                bus.err_unexp_resp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed self-checking bench for mem_ctrl_arbiter (N_CH = 2, MAX_OUTST = 4).
// Latency: n/a.
// Backpressure: memory is always ready; responses are driven by hand per scenario.
module tb_mem_ctrl_arbiter;
    import mem_ctrl_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_ctrl_arbiter_if #(.N_CH(2), .MAX_OUTST(4)) bus ();

    mem_ctrl_arbiter #(.N_CH(2), .MAX_OUTST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ch_req_valid        = '0;
        bus.ch_req_type         = {REQ_READ, REQ_READ};
        bus.ch_req_block_addr   = '0;
        bus.ch_req_block_data   = '0;
        bus.ch_flush            = '0;
        bus.mem_req_ready       = 1'b1;
        bus.mem_resp_valid      = 1'b0;
        bus.mem_resp_block_data = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        if (bus.outst_cnt !== 3'd0) begin
            $display("FAIL reset_outst: got %0d expected 0", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        if (bus.ch_resp_valid !== 2'b00) begin
            $display("FAIL reset_resp_valid: got %b expected 00", bus.ch_resp_valid); n_fail++;
        end
        n_checks++;
        if (bus.ch_resp_block_data !== 64'h0) begin
            $display("FAIL reset_resp_data: got %h expected 0", bus.ch_resp_block_data); n_fail++;
        end
        n_checks++;
        if (bus.err_unexp_resp !== 1'b0) begin
            $display("FAIL reset_err: got %b expected 0", bus.err_unexp_resp); n_fail++;
        end
        n_checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            $display("FAIL reset_mem_req_valid: got %b expected 0", bus.mem_req_valid); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_single_read();
        bus.ch_req_valid         = 2'b01;
        bus.ch_req_block_addr[0] = 26'h10;
        #1;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_block_addr !== 26'h10) begin
            $display("FAIL single_req: got valid=%b addr=%h expected valid=1 addr=10",
                     bus.mem_req_valid, bus.mem_req_block_addr); n_fail++;
        end
        n_checks++;
        if (bus.ch_req_ready !== 2'b01) begin
            $display("FAIL single_ready: got %b expected 01", bus.ch_req_ready); n_fail++;
        end
        n_checks++;
        step();
        bus.ch_req_valid = 2'b00;
        #1;
        if (bus.outst_cnt !== 3'd1) begin
            $display("FAIL single_outst: got %0d expected 1", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        step();
        step();
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
        if (bus.ch_resp_valid !== 2'b00) begin
            $display("FAIL single_early_resp: got %b expected 00", bus.ch_resp_valid); n_fail++;
        end
        n_checks++;
        step();
        bus.mem_resp_valid = 1'b0;
        #1;
        if (bus.ch_resp_valid !== 2'b01 || bus.ch_resp_block_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            $display("FAIL single_resp: got valid=%b data=%h expected valid=01 data=a5a5a5a5a5a5a5a5",
                     bus.ch_resp_valid, bus.ch_resp_block_data); n_fail++;
        end
        n_checks++;
        if (bus.outst_cnt !== 3'd0) begin
            $display("FAIL single_outst_after: got %0d expected 0", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        step();
        if (bus.ch_resp_valid !== 2'b00) begin
            $display("FAIL single_pulse: got %b expected 00", bus.ch_resp_valid); n_fail++;
        end
        n_checks++;
    endtask

    // Leaves four ch0/ch1/ch0/ch1 reads in flight for test_full.
    task automatic test_round_robin();
        logic [1:0]  exp_rdy  [4];
        logic [25:0] exp_addr [4];
        exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_addr = '{26'h100, 26'h200, 26'h100, 26'h200};
        reset_dut();
        bus.ch_req_valid         = 2'b11;
        bus.ch_req_block_addr[0] = 26'h100;
        bus.ch_req_block_addr[1] = 26'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.ch_req_ready !== exp_rdy[k] || bus.mem_req_block_addr !== exp_addr[k]) begin
                $display("FAIL rr_grant%0d: got ready=%b addr=%h expected ready=%b addr=%h",
                         k, bus.ch_req_ready, bus.mem_req_block_addr, exp_rdy[k], exp_addr[k]); n_fail++;
            end
            n_checks++;
            step();
        end
    endtask

    task automatic test_full();
        logic [1:0] exp_ch [4];
        exp_ch = '{2'b10, 2'b01, 2'b10, 2'b01};
        #1;
        if (bus.outst_cnt !== 3'd4) begin
            $display("FAIL full_outst: got %0d expected 4", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        if (bus.ch_req_ready !== 2'b00 || bus.mem_req_valid !== 1'b0) begin
            $display("FAIL full_stall: got ready=%b mem_valid=%b expected 00/0",
                     bus.ch_req_ready, bus.mem_req_valid); n_fail++;
        end
        n_checks++;
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = 64'hF0;
        #1;
        if (bus.ch_req_ready !== 2'b00) begin
            $display("FAIL full_pop_same_cycle: got %b expected 00", bus.ch_req_ready); n_fail++;
        end
        n_checks++;
        step();
        bus.mem_resp_valid = 1'b0;
        #1;
        if (bus.ch_resp_valid !== 2'b01 || bus.outst_cnt !== 3'd3) begin
            $display("FAIL full_first_resp: got resp=%b outst=%0d expected 01/3",
                     bus.ch_resp_valid, bus.outst_cnt); n_fail++;
        end
        n_checks++;
        if (bus.ch_req_ready !== 2'b01) begin
            $display("FAIL full_reaccept: got %b expected 01", bus.ch_req_ready); n_fail++;
        end
        n_checks++;
        step();
        bus.ch_req_valid = 2'b00;
        #1;
        if (bus.outst_cnt !== 3'd4) begin
            $display("FAIL full_refill: got %0d expected 4", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        for (int k = 0; k < 4; k++) begin
            bus.mem_resp_valid      = 1'b1;
            bus.mem_resp_block_data = 64'(k + 1);
            step();
            if (bus.ch_resp_valid !== exp_ch[k] || bus.ch_resp_block_data !== 64'(k + 1)) begin
                $display("FAIL drain%0d: got resp=%b data=%h expected resp=%b data=%h",
                         k, bus.ch_resp_valid, bus.ch_resp_block_data, exp_ch[k], 64'(k + 1)); n_fail++;
            end
            n_checks++;
        end
        bus.mem_resp_valid = 1'b0;
        if (bus.outst_cnt !== 3'd0) begin
            $display("FAIL drain_outst: got %0d expected 0", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        step();
    endtask

    task automatic test_flush();
        logic [1:0]  exp_ch   [3];
        logic [63:0] rsp_data [3];
        exp_ch   = '{2'b00, 2'b10, 2'b00};
        rsp_data = '{64'h11, 64'h22, 64'h33};
        reset_dut();
        bus.ch_req_valid         = 2'b01;
        bus.ch_req_block_addr[0] = 26'h1;
        step();
        bus.ch_req_valid         = 2'b10;
        bus.ch_req_type[1]       = REQ_WRITE;
        bus.ch_req_block_addr[1] = 26'h2;
        bus.ch_req_block_data[1] = 64'hDEAD_BEEF;
        #1;
        if (bus.mem_req_type !== REQ_WRITE || bus.mem_req_block_data !== 64'hDEAD_BEEF) begin
            $display("FAIL flush_write_fields: got type=%b data=%h expected 1/deadbeef",
                     bus.mem_req_type, bus.mem_req_block_data); n_fail++;
        end
        n_checks++;
        step();
        bus.ch_req_valid         = 2'b01;
        bus.ch_req_block_addr[0] = 26'h3;
        step();
        bus.ch_req_valid = 2'b00;
        bus.ch_flush     = 2'b01;
        #1;
        if (bus.outst_cnt !== 3'd3) begin
            $display("FAIL flush_outst: got %0d expected 3", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        step();
        bus.ch_flush = 2'b00;
        for (int k = 0; k < 3; k++) begin
            bus.mem_resp_valid      = 1'b1;
            bus.mem_resp_block_data = rsp_data[k];
            step();
            if (bus.ch_resp_valid !== exp_ch[k]) begin
                $display("FAIL flush_resp%0d: got %b expected %b", k, bus.ch_resp_valid, exp_ch[k]); n_fail++;
            end
            n_checks++;
        end
        bus.mem_resp_valid = 1'b0;
        if (bus.outst_cnt !== 3'd0) begin
            $display("FAIL flush_outst_after: got %0d expected 0", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        bus.ch_req_type[1] = REQ_READ;
        step();
    endtask

    task automatic test_unexpected();
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = 64'h77;
        step();
        bus.mem_resp_valid = 1'b0;
        if (bus.err_unexp_resp !== 1'b1) begin
            $display("FAIL unexp_err: got %b expected 1", bus.err_unexp_resp); n_fail++;
        end
        n_checks++;
        if (bus.ch_resp_valid !== 2'b00 || bus.outst_cnt !== 3'd0) begin
            $display("FAIL unexp_side_effect: got resp=%b outst=%0d expected 00/0",
                     bus.ch_resp_valid, bus.outst_cnt); n_fail++;
        end
        n_checks++;
        step();
        step();
        if (bus.err_unexp_resp !== 1'b1) begin
            $display("FAIL unexp_sticky: got %b expected 1", bus.err_unexp_resp); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_midop();
        bus.ch_req_valid = 2'b11;
        step();
        step();
        bus.ch_req_valid = 2'b00;
        #1;
        if (bus.outst_cnt !== 3'd2) begin
            $display("FAIL midop_outst_before: got %0d expected 2", bus.outst_cnt); n_fail++;
        end
        n_checks++;
        rst                     = 1'b1;
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = 64'h99;
        step();
        rst                = 1'b0;
        bus.mem_resp_valid = 1'b0;
        if (bus.outst_cnt !== 3'd0 || bus.ch_resp_valid !== 2'b00 || bus.err_unexp_resp !== 1'b0) begin
            $display("FAIL midop_reset: got outst=%0d resp=%b err=%b expected 0/00/0",
                     bus.outst_cnt, bus.ch_resp_valid, bus.err_unexp_resp); n_fail++;
        end
        n_checks++;
        bus.ch_req_valid = 2'b11;
        #1;
        if (bus.ch_req_ready !== 2'b01) begin
            $display("FAIL midop_rr_ptr: got ready=%b expected 01", bus.ch_req_ready); n_fail++;
        end
        n_checks++;
        bus.ch_req_valid = 2'b00;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_full();
        test_flush();
        test_unexpected();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
